// File: rtl/lsu_dccm_pkg.sv
// Shared types and address helpers for the LSU DCCM bank controller.
// The read-stage record is sized for the widest supported tag and bank count.
package lsu_dccm_pkg;

  localparam int STG_TAG_W  = 8;
  localparam int STG_BANK_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [STG_TAG_W-1:0]  tag;
    logic [STG_BANK_W-1:0] lo_bank;
    logic [STG_BANK_W-1:0] hi_bank;
  } rd_stage_t;

  function automatic logic [STG_BANK_W-1:0] bank_idx(input logic [31:0] addr,
                                                     input int bb, input int bnk);
    logic [31:0] mask;
    mask = (32'd1 << bnk) - 32'd1;
    return STG_BANK_W'((addr >> bb) & mask);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr,
                                            input int bb, input int bnk);
    return addr >> (bb + bnk);
  endfunction

endpackage

// File: rtl/lsu_dccm_bank_ctl_rd_pipe.sv
// Read tracking pipe: RD_LAT-deep stage shift register followed by a registered,
// tagged lo/hi response capture from the selected bank read data.
module lsu_dccm_rd_pipe
  import lsu_dccm_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int FDATA_W   = 39,
  parameter int RD_LAT    = 1,
  parameter int TAG_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_l_i,
  input  logic                         flush_i,
  input  rd_stage_t                    req_i,
  input  logic [NUM_BANKS*FDATA_W-1:0] bank_rd_data_i,
  output logic                         rsp_valid_o,
  output logic [TAG_W-1:0]             rsp_tag_o,
  output logic [FDATA_W-1:0]           rsp_data_lo_o,
  output logic [FDATA_W-1:0]           rsp_data_hi_o
);

  rd_stage_t stg_q [RD_LAT];
  rd_stage_t stg_d [RD_LAT];
  rd_stage_t last;

  logic               rsp_valid_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic [FDATA_W-1:0] rsp_lo_q;
  logic [FDATA_W-1:0] rsp_hi_q;

  // Flush also kills the request entering stage 0 in the same cycle.
  always_comb begin
    stg_d[0] = req_i;
    for (int i = 1; i < RD_LAT; i++) stg_d[i] = stg_q[i-1];
    for (int i = 0; i < RD_LAT; i++) begin
      if (flush_i) stg_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      for (int i = 0; i < RD_LAT; i++) stg_q[i] <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign last = stg_q[RD_LAT-1];

  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
    end else begin
      rsp_valid_q <= last.valid & ~flush_i;
      if (last.valid) begin
        rsp_tag_q <= TAG_W'(last.tag);
        rsp_lo_q  <= bank_rd_data_i[last.lo_bank*FDATA_W +: FDATA_W];
        rsp_hi_q  <= bank_rd_data_i[last.hi_bank*FDATA_W +: FDATA_W];
      end
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_tag_o     = rsp_tag_q;
  assign rsp_data_lo_o = rsp_lo_q;
  assign rsp_data_hi_o = rsp_hi_q;

endmodule

// File: rtl/lsu_dccm_bank_ctl.sv
// LSU DCCM bank controller: per-bank read/write arbitration and tagged read return.
// Build option LSU_DCCM_STARVE_EN: a write deferred MAX_DEFER times in a row wins its next conflict.
module lsu_dccm_bank_ctl
  import lsu_dccm_pkg::*;
#(
  parameter int  NUM_BANKS = 4,
  parameter int  BYTE_W    = 4,
  parameter int  ECC_W     = 7,
  parameter int  ADDR_W    = 16,
  parameter int  RD_LAT    = 1,
  parameter int  TAG_W     = 4,
  parameter int  MAX_DEFER = 3,
  localparam int FDATA_W   = 8*BYTE_W + ECC_W,
  localparam int BB        = $clog2(BYTE_W),
  localparam int BNK       = $clog2(NUM_BANKS),
  localparam int WA_W      = ADDR_W - BB - BNK
) (
  input  logic                         clk_i,
  input  logic                         rst_l_i,
  input  logic                         flush_i,
  input  logic                         rd_valid_i,
  output logic                         rd_ready_o,
  input  logic [ADDR_W-1:0]            rd_addr_lo_i,
  input  logic [ADDR_W-1:0]            rd_addr_hi_i,
  input  logic [TAG_W-1:0]             rd_tag_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [FDATA_W-1:0]           wr_data_i,
  output logic                         rsp_valid_o,
  output logic [TAG_W-1:0]             rsp_tag_o,
  output logic [FDATA_W-1:0]           rsp_data_lo_o,
  output logic [FDATA_W-1:0]           rsp_data_hi_o,
  output logic [NUM_BANKS-1:0]         bank_rden_o,
  output logic [NUM_BANKS-1:0]         bank_wren_o,
  output logic [NUM_BANKS*WA_W-1:0]    bank_addr_o,
  output logic [FDATA_W-1:0]           bank_wr_data_o,
  input  logic [NUM_BANKS*FDATA_W-1:0] bank_rd_data_i
);

  logic [STG_BANK_W-1:0] lo_bank, hi_bank, wr_bank;
  logic [WA_W-1:0]       lo_word, hi_word, wr_word;
  logic                  conflict, wr_wins, rd_accept, wr_accept;
  rd_stage_t             rd_req;

  assign lo_bank = bank_idx(32'(rd_addr_lo_i), BB, BNK);
  assign hi_bank = bank_idx(32'(rd_addr_hi_i), BB, BNK);
  assign wr_bank = bank_idx(32'(wr_addr_i), BB, BNK);
  assign lo_word = WA_W'(word_addr(32'(rd_addr_lo_i), BB, BNK));
  assign hi_word = WA_W'(word_addr(32'(rd_addr_hi_i), BB, BNK));
  assign wr_word = WA_W'(word_addr(32'(wr_addr_i), BB, BNK));

  assign conflict = rd_valid_i & wr_valid_i & ((wr_bank == lo_bank) | (wr_bank == hi_bank));

`ifdef LSU_DCCM_STARVE_EN
  localparam logic [3:0] DEFER_MAX = 4'(MAX_DEFER);
  logic [3:0] defer_q, defer_d;

  assign wr_wins = conflict & (defer_q == DEFER_MAX);

  always_comb begin
    defer_d = defer_q;
    if (!wr_valid_i || wr_accept)                defer_d = '0;
    else if (conflict && (defer_q != DEFER_MAX)) defer_d = defer_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_l_i) defer_q <= '0;
    else          defer_q <= defer_d;
  end
`else
  localparam int unused_max_defer = MAX_DEFER;
  assign wr_wins = 1'b0;
`endif

  assign rd_ready_o = ~wr_wins;
  assign wr_ready_o = ~conflict | wr_wins;
  assign rd_accept  = rd_valid_i & rd_ready_o;
  assign wr_accept  = wr_valid_i & wr_ready_o;

  // Arbitration guarantees an accepted write never shares a bank with an accepted read.
  always_comb begin
    bank_rden_o = '0;
    bank_wren_o = '0;
    bank_addr_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_accept && (wr_bank == STG_BANK_W'(b))) begin
        bank_wren_o[b]            = 1'b1;
        bank_addr_o[b*WA_W +: WA_W] = wr_word;
      end else begin
        if (rd_accept && ((lo_bank == STG_BANK_W'(b)) || (hi_bank == STG_BANK_W'(b))))
          bank_rden_o[b] = 1'b1;
        bank_addr_o[b*WA_W +: WA_W] = ((hi_bank == STG_BANK_W'(b)) && (lo_bank != STG_BANK_W'(b)))
                                      ? hi_word : lo_word;
      end
    end
  end

  assign bank_wr_data_o = wr_data_i;

  always_comb begin
    rd_req         = '0;
    rd_req.valid   = rd_accept;
    rd_req.tag     = STG_TAG_W'(rd_tag_i);
    rd_req.lo_bank = lo_bank;
    rd_req.hi_bank = hi_bank;
  end

  lsu_dccm_rd_pipe #(
    .NUM_BANKS (NUM_BANKS),
    .FDATA_W   (FDATA_W),
    .RD_LAT    (RD_LAT),
    .TAG_W     (TAG_W)
  ) u_rd_pipe (
    .clk_i          (clk_i),
    .rst_l_i        (rst_l_i),
    .flush_i        (flush_i),
    .req_i          (rd_req),
    .bank_rd_data_i (bank_rd_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_tag_o      (rsp_tag_o),
    .rsp_data_lo_o  (rsp_data_lo_o),
    .rsp_data_hi_o  (rsp_data_hi_o)
  );

endmodule

// File: tb/tb_lsu_dccm_bank_ctl.sv
// Bench for lsu_dccm_bank_ctl: two instances (RD_LAT 1 and 3) share stimulus; responses
// are checked against a per-instance queue of expected {due cycle, tag, lo, hi}.
module tb_lsu_dccm_bank_ctl;

  localparam int FW = 39;
  localparam int NB = 4;
  localparam int WA = 12;
`ifdef LSU_DCCM_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  localparam logic [FW-1:0] JUNK = 39'h55_DEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_l, flush, rd_valid, wr_valid;
  logic [15:0]   rd_addr_lo, rd_addr_hi, wr_addr;
  logic [3:0]    rd_tag;
  logic [FW-1:0] wr_data;

  logic             rd_ready1, wr_ready1, rsp_valid1, rd_ready3, wr_ready3, rsp_valid3;
  logic [3:0]       rsp_tag1, rsp_tag3, rden1, wren1, rden3, wren3;
  logic [FW-1:0]    rsp_lo1, rsp_hi1, rsp_lo3, rsp_hi3, bwd1, bwd3;
  logic [NB*WA-1:0] baddr1, baddr3;
  logic [NB*FW-1:0] brd1, brd3;

  lsu_dccm_bank_ctl #(.RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_l_i(rst_l), .flush_i(flush),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready1), .rd_addr_lo_i(rd_addr_lo),
    .rd_addr_hi_i(rd_addr_hi), .rd_tag_i(rd_tag),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready1), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsp_valid_o(rsp_valid1), .rsp_tag_o(rsp_tag1), .rsp_data_lo_o(rsp_lo1), .rsp_data_hi_o(rsp_hi1),
    .bank_rden_o(rden1), .bank_wren_o(wren1), .bank_addr_o(baddr1),
    .bank_wr_data_o(bwd1), .bank_rd_data_i(brd1)
  );

  lsu_dccm_bank_ctl #(.RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_l_i(rst_l), .flush_i(flush),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready3), .rd_addr_lo_i(rd_addr_lo),
    .rd_addr_hi_i(rd_addr_hi), .rd_tag_i(rd_tag),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready3), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsp_valid_o(rsp_valid3), .rsp_tag_o(rsp_tag3), .rsp_data_lo_o(rsp_lo3), .rsp_data_hi_o(rsp_hi3),
    .bank_rden_o(rden3), .bank_wren_o(wren3), .bank_addr_o(baddr3),
    .bank_wr_data_o(bwd3), .bank_rd_data_i(brd3)
  );

  function automatic logic [FW-1:0] mem_word(input int b, input int w);
    return {7'(b*3 + 1), 8'hA5, 8'(b), 16'(w)};
  endfunction
  function automatic int bank_of(input logic [15:0] a);
    return int'((a >> 2) & 16'h3);
  endfunction
  function automatic int word_of(input logic [15:0] a);
    return int'(a >> 4);
  endfunction

  // SRAM models: data appears RD_LAT cycles after rden, junk otherwise.
  logic [FW-1:0] p1 [NB];
  logic [FW-1:0] p3a [NB];
  logic [FW-1:0] p3b [NB];
  logic [FW-1:0] p3c [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      p1[b]  <= rden1[b] ? mem_word(b, int'(baddr1[b*WA +: WA])) : JUNK;
      p3a[b] <= rden3[b] ? mem_word(b, int'(baddr3[b*WA +: WA])) : JUNK;
      p3b[b] <= p3a[b];
      p3c[b] <= p3b[b];
    end
  end
  always_comb begin
    brd1 = '0;
    brd3 = '0;
    for (int b = 0; b < NB; b++) begin
      brd1[b*FW +: FW] = p1[b];
      brd3[b*FW +: FW] = p3c[b];
    end
  end

  typedef struct {
    int            due;
    logic [3:0]    tag;
    logic [FW-1:0] lo;
    logic [FW-1:0] hi;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        if (rsp_valid1 !== 1'b1 || rsp_tag1 !== q1[0].tag || rsp_lo1 !== q1[0].lo || rsp_hi1 !== q1[0].hi) begin
          errors++;
          $display("FAIL rsp_lat1 cyc=%0d got v=%b tag=%h lo=%h hi=%h exp tag=%h lo=%h hi=%h",
                   cyc, rsp_valid1, rsp_tag1, rsp_lo1, rsp_hi1, q1[0].tag, q1[0].lo, q1[0].hi);
        end
        void'(q1.pop_front());
      end else if (rsp_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL rsp_lat1_spurious cyc=%0d got rsp_valid=%b exp 0", cyc, rsp_valid1);
      end
      checks++;
      if (q3.size() > 0 && q3[0].due == cyc) begin
        if (rsp_valid3 !== 1'b1 || rsp_tag3 !== q3[0].tag || rsp_lo3 !== q3[0].lo || rsp_hi3 !== q3[0].hi) begin
          errors++;
          $display("FAIL rsp_lat3 cyc=%0d got v=%b tag=%h lo=%h hi=%h exp tag=%h lo=%h hi=%h",
                   cyc, rsp_valid3, rsp_tag3, rsp_lo3, rsp_hi3, q3[0].tag, q3[0].lo, q3[0].hi);
        end
        void'(q3.pop_front());
      end else if (rsp_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL rsp_lat3_spurious cyc=%0d got rsp_valid=%b exp 0", cyc, rsp_valid3);
      end
    end
  end

  // One cycle of stimulus; leaves the caller at posedge+2 for combinational checks.
  task automatic drive(input bit rst, input bit fl, input bit rv, input logic [15:0] lo,
                       input logic [15:0] hi, input logic [3:0] tag, input bit wv,
                       input logic [15:0] wa, input logic [FW-1:0] wd, input bit rd_acc);
    exp_t e;
    exp_t keep1[$];
    exp_t keep3[$];
    @(posedge clk);
    #1;
    rst_l = ~rst; flush = fl; rd_valid = rv; rd_addr_lo = lo; rd_addr_hi = hi;
    rd_tag = tag; wr_valid = wv; wr_addr = wa; wr_data = wd;
    if (fl || rst) begin
      foreach (q1[i]) if (q1[i].due <= cyc) keep1.push_back(q1[i]);
      foreach (q3[i]) if (q3[i].due <= cyc) keep3.push_back(q3[i]);
      q1 = keep1;
      q3 = keep3;
    end else if (rd_acc) begin
      e.tag = tag;
      e.lo  = mem_word(bank_of(lo), word_of(lo));
      e.hi  = mem_word(bank_of(hi), word_of(hi));
      e.due = cyc + 2;
      q1.push_back(e);
      e.due = cyc + 4;
      q3.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid1 got %b exp 0", rsp_valid1); end
    checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid3 got %b exp 0", rsp_valid3); end
    checks++; if (rsp_tag1 !== 4'h0) begin errors++; $display("FAIL reset_rsp_tag got %h exp 0", rsp_tag1); end
    checks++; if (rsp_lo1 !== '0 || rsp_hi3 !== '0) begin errors++; $display("FAIL reset_rsp_data got lo=%h hi=%h exp 0", rsp_lo1, rsp_hi3); end
    checks++; if (rden1 !== 4'b0 || wren1 !== 4'b0) begin errors++; $display("FAIL reset_bank_en got rden=%b wren=%b exp 0", rden1, wren1); end
    mon_en = 1'b1;
    idle(1);
  endtask

  task automatic test_aligned();
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0013, 4'd5, 1'b0, '0, '0, 1'b1);
    checks++; if (rd_ready1 !== 1'b1) begin errors++; $display("FAIL aligned_rd_ready got %b exp 1", rd_ready1); end
    checks++; if (rden1 !== 4'b0001 || rden3 !== 4'b0001) begin errors++; $display("FAIL aligned_rden got %b/%b exp 0001", rden1, rden3); end
    checks++; if (baddr1[0 +: WA] !== 12'd1) begin errors++; $display("FAIL aligned_addr got %h exp 1", baddr1[0 +: WA]); end
    checks++; if (wren1 !== 4'b0000) begin errors++; $display("FAIL aligned_wren got %b exp 0000", wren1); end
    idle(5);
  endtask

  task automatic test_unaligned();
    drive(1'b0, 1'b0, 1'b1, 16'h000E, 16'h0011, 4'd9, 1'b0, '0, '0, 1'b1);
    checks++; if (rden1 !== 4'b1001) begin errors++; $display("FAIL unaligned_rden got %b exp 1001", rden1); end
    checks++; if (baddr1[3*WA +: WA] !== 12'd0 || baddr1[0 +: WA] !== 12'd1) begin
      errors++; $display("FAIL unaligned_addr got b3=%h b0=%h exp 0/1", baddr1[3*WA +: WA], baddr1[0 +: WA]);
    end
    idle(5);
  endtask

  task automatic test_no_conflict();
    drive(1'b0, 1'b0, 1'b1, 16'h0034, 16'h0037, 4'd3, 1'b1, 16'h0028, 39'h12_3456_789A, 1'b1);
    checks++; if (rd_ready1 !== 1'b1 || wr_ready1 !== 1'b1) begin errors++; $display("FAIL nocfl_ready got rd=%b wr=%b exp 1/1", rd_ready1, wr_ready1); end
    checks++; if (wren1 !== 4'b0100) begin errors++; $display("FAIL nocfl_wren got %b exp 0100", wren1); end
    checks++; if (rden1 !== 4'b0010) begin errors++; $display("FAIL nocfl_rden got %b exp 0010", rden1); end
    checks++; if (baddr1[2*WA +: WA] !== 12'd2 || baddr1[1*WA +: WA] !== 12'd3) begin
      errors++; $display("FAIL nocfl_addr got b2=%h b1=%h exp 2/3", baddr1[2*WA +: WA], baddr1[1*WA +: WA]);
    end
    checks++; if (bwd1 !== 39'h12_3456_789A) begin errors++; $display("FAIL nocfl_wdata got %h exp 123456789a", bwd1); end
    idle(5);
  endtask

  task automatic test_starve();
    bit wv_s  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit win_s [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      bit win;
      win = STARVE && win_s[i];
      drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0023, 4'(i), wv_s[i], 16'h0000, 39'(i), !win);
      checks++; if (wr_ready1 !== (win | !wv_s[i])) begin errors++; $display("FAIL starve_wr_ready step=%0d got %b exp %b", i, wr_ready1, win | !wv_s[i]); end
      checks++; if (rd_ready1 !== !win) begin errors++; $display("FAIL starve_rd_ready step=%0d got %b exp %b", i, rd_ready1, !win); end
      checks++; if (wren1 !== {3'b000, win} || rden1 !== {3'b000, !win}) begin
        errors++; $display("FAIL starve_bank_en step=%0d got wren=%b rden=%b exp win=%b", i, wren1, rden1, win);
      end
      checks++; if (baddr1[0 +: WA] !== (win ? 12'd0 : 12'd2)) begin errors++; $display("FAIL starve_addr step=%0d got %h", i, baddr1[0 +: WA]); end
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    logic [15:0] lo_s [4] = '{16'h0000, 16'h0014, 16'h0028, 16'h003E};
    logic [15:0] hi_s [4] = '{16'h0003, 16'h0017, 16'h002B, 16'h0041};
    logic [3:0]  en_s [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, lo_s[i], hi_s[i], 4'(i + 1), 1'b0, '0, '0, 1'b1);
      checks++; if (rden3 !== en_s[i]) begin errors++; $display("FAIL b2b_rden step=%0d got %b exp %b", i, rden3, en_s[i]); end
    end
    idle(6);
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0007, 4'd1, 1'b0, '0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h0048, 16'h004B, 4'd2, 1'b1, 16'h0000, 39'h7, 1'b1);
    checks++; if (rden1 !== 4'b0100 || wren1 !== 4'b0001) begin
      errors++; $display("FAIL flush_bank_en got rden=%b wren=%b exp 0100/0001", rden1, wren1);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h000C, 16'h000F, 4'd3, 1'b0, '0, '0, 1'b1);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0033, 4'd4, 1'b0, '0, '0, 1'b1);
    idle(6);
  endtask

  task automatic test_reset_midflight();
    drive(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0007, 4'd6, 1'b1, 16'h0044, 39'h1, 1'b1);
    checks++; if (wr_ready1 !== 1'b0) begin errors++; $display("FAIL rstmid_defer1 got %b exp 0", wr_ready1); end
    drive(1'b0, 1'b0, 1'b1, 16'h0014, 16'h0017, 4'd7, 1'b1, 16'h0044, 39'h1, 1'b1);
    checks++; if (wr_ready1 !== 1'b0) begin errors++; $display("FAIL rstmid_defer2 got %b exp 0", wr_ready1); end
    drive(1'b1, 1'b0, 1'b1, 16'h0014, 16'h0017, 4'd8, 1'b1, 16'h0044, 39'h1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit win;
      win = STARVE && (i == 3);
      drive(1'b0, 1'b0, 1'b1, 16'h0014, 16'h0017, 4'(9 + i), 1'b1, 16'h0044, 39'h2, !win);
      checks++; if (wr_ready1 !== win || rd_ready1 !== !win) begin
        errors++; $display("FAIL rstmid_defer_clear step=%0d got wr=%b rd=%b exp wr=%b", i, wr_ready1, rd_ready1, win);
      end
      if (i == 0) begin
        checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid got %b exp 0", rsp_valid3); end
      end
    end
    idle(6);
  endtask

  initial begin
    rst_l = 1'b0; flush = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
    rd_addr_lo = '0; rd_addr_hi = '0; rd_tag = '0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_no_conflict();
    test_starve();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    idle(4);
    checks++; if (q1.size() != 0 || q3.size() != 0) begin
      errors++; $display("FAIL drain got q1=%0d q3=%0d exp 0/0", q1.size(), q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
